alu_flag_writeback: RTL and testbench

// - Stage directly downstream of the ALU. Captures each ALU result Y and its flags {C,Z,N,V}.
// - Holds the architectural condition-code register (CCR) and evaluates the 4-bit condition field.
// - Applies flag updates in order; presents register writebacks through a 2-entry valid/ready buffer.
// - Decouples the ALU from register-file write stalls.

---
 rtl/alu_flag_writeback.sv | 139 +++++++++++++
 tb/tb_alu_flag_writeback.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_flag_writeback.sv
// ALU writeback stage: owns the condition-code register, evaluates the condition field and
// queues register writebacks through a 2-entry in-order valid/ready buffer.
module alu_flag_writeback #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_y,
  input  logic [3:0]        alu_flags,
  input  logic              set_flags,
  input  logic [3:0]        cond,
  input  logic              wr_req,
  input  logic [REG_AW-1:0] rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_pass,
  output logic [3:0]        ccr
);

  typedef struct packed {
    logic [DATA_W-1:0] y;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              pass;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  entry_t     head_q, head_d, tail_q, tail_d, in_entry;
  logic [3:0] ccr_q, ccr_d;
  logic       pass_c, push, pop;
  logic       f_c, f_z, f_n, f_v;

  assign {f_c, f_z, f_n, f_v} = ccr_q;

  // Condition outcome against the CCR as it stands this cycle
  always_comb begin
    pass_c = 1'b0;
    case (cond)
      4'h0: pass_c = f_z;
      4'h1: pass_c = !f_z;
      4'h2: pass_c = f_c;
      4'h3: pass_c = !f_c;
      4'h4: pass_c = f_n;
      4'h5: pass_c = !f_n;
      4'h6: pass_c = f_v;
      4'h7: pass_c = !f_v;
      4'h8: pass_c = f_c && !f_z;
      4'h9: pass_c = !f_c || f_z;
      4'hA: pass_c = (f_n == f_v);
      4'hB: pass_c = (f_n != f_v);
      4'hC: pass_c = !f_z && (f_n == f_v);
      4'hD: pass_c = f_z || (f_n != f_v);
      4'hE: pass_c = 1'b1;
      default: pass_c = 1'b0;
    endcase
  end

  assign in_ready  = (state_q != FULL) && !flush;
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    in_entry      = '0;
    in_entry.y    = alu_y;
    in_entry.rd   = rd;
    in_entry.wr   = wr_req;
    in_entry.pass = pass_c;
  end

  // Buffer occupancy FSM plus CCR update
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    ccr_d   = ccr_q;
    if (push && pass_c && set_flags) ccr_d = alu_flags;
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = in_entry;
        end else if (push) begin
          tail_d  = in_entry;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      ccr_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ccr_q   <= ccr_d;
    end
  end

  assign wb_data = head_q.y;
  assign wb_rd   = head_q.rd;
  assign wb_pass = head_q.pass;
  assign wb_en   = out_valid && head_q.pass && head_q.wr;
  assign ccr     = ccr_q;

endmodule

// File: tb/tb_alu_flag_writeback.sv
// Bench for alu_flag_writeback: directed scenarios followed by random traffic, all checked
// against a queue-based reference model of the stage.
module tb_alu_flag_writeback;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, set_flags, wr_req;
  logic          out_valid, out_ready, wb_en, wb_pass;
  logic [DW-1:0] alu_y, wb_data;
  logic [3:0]    alu_flags, cond, ccr;
  logic [AW-1:0] rd, wb_rd;

  always #5 clk = ~clk;

  alu_flag_writeback #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_y(alu_y), .alu_flags(alu_flags), .set_flags(set_flags), .cond(cond),
    .wr_req(wr_req), .rd(rd), .out_valid(out_valid), .out_ready(out_ready),
    .wb_en(wb_en), .wb_data(wb_data), .wb_rd(wb_rd), .wb_pass(wb_pass), .ccr(ccr)
  );

  typedef struct {
    logic [DW-1:0] y;
    logic [AW-1:0] rd;
    logic          wr;
    logic          pass;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] popped[$];
  logic [3:0]    m_ccr = 4'h0;
  logic [3:0]    saved_ccr;
  bit            pristine = 1'b1;
  int            errors = 0;
  int            checks = 0;

  // Even codes are base tests, odd codes their inversions
  function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
    logic       fc, fz, fn, fv;
    logic [7:0] base;
    fc = f[3]; fz = f[2]; fn = f[1]; fv = f[0];
    base = {1'b1, !fz && (fn == fv), fn == fv, fc && !fz, fv, fn, fc, fz};
    return c[0] ? !base[c[3:1]] : base[c[3:1]];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic a_v, input logic [DW-1:0] a_y, input logic [3:0] a_fl,
                      input logic a_sf, input logic [3:0] a_cd, input logic a_wr,
                      input logic [AW-1:0] a_rd, input logic a_ordy,
                      input logic a_flush, input logic a_rst);
    bit   acc, pp, p;
    ent_t e;
    @(negedge clk);
    reset = a_rst; flush = a_flush; in_valid = a_v; alu_y = a_y; alu_flags = a_fl;
    set_flags = a_sf; cond = a_cd; wr_req = a_wr; rd = a_rd; out_ready = a_ordy;
    #1;
    if (!a_rst) check("in_ready", 32'(in_ready), 32'(q.size() < 2 && !a_flush));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("ccr", 32'(ccr), 32'(m_ccr));
    if (q.size() != 0) begin
      check("wb_data", wb_data, q[0].y);
      check("wb_rd", 32'(wb_rd), 32'(q[0].rd));
      check("wb_pass", 32'(wb_pass), 32'(q[0].pass));
      check("wb_en", 32'(wb_en), 32'(q[0].pass && q[0].wr));
    end else begin
      check("wb_en_idle", 32'(wb_en), 32'(0));
    end
    if (pristine) begin
      check("wb_data_rst", wb_data, 32'(0));
      check("wb_rd_rst", 32'(wb_rd), 32'(0));
      check("wb_pass_rst", 32'(wb_pass), 32'(0));
    end
    if (!a_rst && out_valid === 1'b1 && a_ordy) popped.push_back(wb_data);
    @(posedge clk);
    if (a_rst) begin
      q.delete();
      m_ccr = 4'h0;
      pristine = 1'b1;
    end else begin
      pp  = (q.size() != 0) && a_ordy;
      acc = a_v && (q.size() < 2) && !a_flush;
      if (pp) void'(q.pop_front());
      if (acc) begin
        p = cond_true(a_cd, m_ccr);
        if (p && a_sf) m_ccr = a_fl;
        e.y = a_y; e.rd = a_rd; e.wr = a_wr; e.pass = p;
        q.push_back(e);
        pristine = 1'b0;
      end
      if (a_flush) q.delete();
    end
  endtask

  task automatic idle(input logic a_ordy);
    step(1'b0, '0, 4'h0, 1'b0, 4'hE, 1'b0, '0, a_ordy, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [DW-1:0] y, input logic [3:0] fl, input logic sf,
                      input logic [3:0] cd, input logic [AW-1:0] r, input logic a_ordy);
    step(1'b1, y, fl, sf, cd, 1'b1, r, a_ordy, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; alu_y = '0; alu_flags = '0;
    set_flags = 1'b0; cond = '0; wr_req = 1'b0; rd = '0; out_ready = 1'b0;

    step(1'b0, '0, 4'h0, 1'b0, 4'h0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 4'h0, 1'b0, 4'h0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);

    // Flag update through an always-true condition
    push(32'd0, 4'b0100, 1'b1, 4'hE, 4'd3, 1'b1);
    #2;
    check("flagupd_ccr", 32'(ccr), 32'h4);
    check("flagupd_wb_en", 32'(wb_en), 32'd1);
    check("flagupd_wb_data", wb_data, 32'd0);
    check("flagupd_wb_rd", 32'(wb_rd), 32'd3);

    // NE fails with Z set: no flag update, no writeback; EQ then passes
    push(32'd5, 4'b1000, 1'b1, 4'h1, 4'd4, 1'b1);
    #2;
    check("gate_pass", 32'(wb_pass), 32'd0);
    check("gate_en", 32'(wb_en), 32'd0);
    check("gate_ccr", 32'(ccr), 32'h4);
    push(32'd6, 4'b0000, 1'b0, 4'h0, 4'd5, 1'b1);
    #2;
    check("gate_eq_en", 32'(wb_en), 32'd1);
    idle(1'b1);

    // Backpressure: third push held off until the buffer drains
    popped.delete();
    push(32'd1, 4'h0, 1'b0, 4'hE, 4'd1, 1'b0);
    push(32'd2, 4'h0, 1'b0, 4'hE, 4'd2, 1'b0);
    push(32'd3, 4'h0, 1'b0, 4'hE, 4'd3, 1'b0);
    push(32'd3, 4'h0, 1'b0, 4'hE, 4'd3, 1'b1);
    push(32'd3, 4'h0, 1'b0, 4'hE, 4'd3, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("bp_count", 32'(popped.size()), 32'd3);
    for (int i = 0; i < 3 && i < popped.size(); i++)
      check("bp_order", popped[i], 32'(i + 1));

    // Push+pop with one entry: N=1,V=1 then GE passes
    push(32'd20, 4'b0011, 1'b1, 4'hE, 4'd7, 1'b1);
    push(32'd21, 4'b0000, 1'b0, 4'hA, 4'd8, 1'b1);
    #2;
    check("chain_ge_pass", 32'(wb_pass), 32'd1);
    check("chain_data", wb_data, 32'd21);
    push(32'd22, 4'b0000, 1'b0, 4'hB, 4'd9, 1'b1);
    #2;
    check("chain_lt_fail", 32'(wb_pass), 32'd0);
    idle(1'b1);

    // Flush while full with input offered
    push(32'd30, 4'h0, 1'b0, 4'hE, 4'd1, 1'b0);
    push(32'd31, 4'h0, 1'b0, 4'hE, 4'd2, 1'b0);
    saved_ccr = m_ccr;
    step(1'b1, 32'd32, 4'hF, 1'b1, 4'hE, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0);
    #2;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ccr", 32'(ccr), 32'(saved_ccr));
    idle(1'b0);

    // Reset while full, mid-stall, with flush and handshake active
    push(32'd40, 4'hF, 1'b1, 4'hE, 4'd1, 1'b0);
    push(32'd41, 4'h0, 1'b0, 4'hE, 4'd2, 1'b0);
    step(1'b1, 32'd42, 4'hF, 1'b1, 4'hE, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1);
    #2;
    check("rst_full_valid", 32'(out_valid), 32'd0);
    check("rst_full_ccr", 32'(ccr), 32'd0);
    check("rst_full_data", wb_data, 32'd0);
    idle(1'b0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(3, 0) != 0, $urandom, 4'($urandom), 1'($urandom),
           4'($urandom), 1'($urandom), AW'($urandom), $urandom_range(1, 0) != 0,
           $urandom_range(15, 0) == 0, $urandom_range(63, 0) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
